// File: rtl/orb_ctrl_pkg.sv
// rtl/orb_ctrl_pkg.sv - shared state encoding and default frame geometry for the ORB frame controller
package orb_ctrl_pkg;

    localparam int DEF_IMG_W   = 512;
    localparam int DEF_IMG_H   = 480;
    localparam int DEF_LATENCY = 11504;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Bit width able to index n items, never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/orb_coord_counter.sv
// rtl/orb_coord_counter.sv - column/row raster position counter with wrap, enable and clear
module orb_coord_counter #(
    parameter int COLS = 8,
    parameter int ROWS = 4,
    parameter int CW   = 3,
    parameter int RW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Next position: clear has priority, otherwise step through the raster and wrap at the frame end.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            if (col_q == CW'(COLS - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/orb_frame_controller.sv
// rtl/orb_frame_controller.sv - frame sequencing, pipeline gating and descriptor tagging for an ORB pipeline
module orb_frame_controller
    import orb_ctrl_pkg::*;
#(
    parameter int IMG_W             = DEF_IMG_W,
    parameter int IMG_H             = DEF_IMG_H,
    parameter int LATENCY           = DEF_LATENCY,
    parameter int WIDTH_PIXEL       = 8,
    parameter int WIDTH_DESCRIPTORS = 256,
    localparam int CW               = ctr_width(IMG_W),
    localparam int RW               = ctr_width(IMG_H),
    localparam int LW               = ctr_width(LATENCY + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    input  logic [WIDTH_PIXEL-1:0]       in_pixel,
    input  logic                         in_corner,
    output logic                         in_ready,
    output logic                         pipe_ena,
    output logic [WIDTH_PIXEL-1:0]       pipe_pixel,
    output logic                         pipe_corner,
    input  logic [WIDTH_DESCRIPTORS-1:0] pipe_desc,
    input  logic                         pipe_valid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH_DESCRIPTORS-1:0] out_desc,
    output logic [CW-1:0]                out_col,
    output logic [RW-1:0]                out_row,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overflow
);

    state_e                       state_q;
    logic [LW-1:0]                flush_cnt_q;
    logic                         frame_done_q;
    logic [LW-1:0]                en_cnt_q;
    logic                         out_valid_q;
    logic [WIDTH_DESCRIPTORS-1:0] out_desc_q;
    logic [CW-1:0]                out_col_q;
    logic [RW-1:0]                out_row_q;
    logic                         overflow_q;

    logic          streaming, flushing, stall, xfer, go, kill, clr;
    logic          lat_reached, out_adv, capture, in_last;
    logic [CW-1:0] in_col, oc_col;
    logic [RW-1:0] in_row, oc_row;

    // The pipeline is frozen while a held descriptor waits on the downstream side.
    assign stall     = out_valid_q & ~out_ready;
    assign streaming = (state_q == ST_STREAM);
    assign flushing  = (state_q == ST_FLUSH);
    assign in_ready  = streaming & ~stall;
    assign xfer      = streaming & in_valid & ~stall;
    assign pipe_ena  = xfer | (flushing & ~stall);

    // Only real pixels reach the pipeline; flush cycles and idle cycles feed zeros.
    assign pipe_pixel  = xfer ? in_pixel  : '0;
    assign pipe_corner = xfer ? in_corner : 1'b0;

    // An accepted start and an abort of a running frame both restart all frame bookkeeping.
    assign go   = (state_q == ST_IDLE) & start & ~abort;
    assign kill = (state_q != ST_IDLE) & abort;
    assign clr  = go | kill;

    // Output coordinates begin moving once the first pixel has had time to traverse the pipeline.
    assign lat_reached = (en_cnt_q == LW'(LATENCY));
    assign out_adv     = pipe_ena & lat_reached;
    assign capture     = pipe_ena & pipe_valid;

    assign in_last = (in_col == CW'(IMG_W - 1)) & (in_row == RW'(IMG_H - 1));

    orb_coord_counter #(
        .COLS (IMG_W),
        .ROWS (IMG_H),
        .CW   (CW),
        .RW   (RW)
    ) u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .en_i  (xfer),
        .col_o (in_col),
        .row_o (in_row)
    );

    orb_coord_counter #(
        .COLS (IMG_W),
        .ROWS (IMG_H),
        .CW   (CW),
        .RW   (RW)
    ) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .en_i  (out_adv),
        .col_o (oc_col),
        .row_o (oc_row)
    );

    // Frame sequencer: idle, accept pixels, then drain the pipeline for exactly LATENCY enabled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q     <= ST_STREAM;
                        flush_cnt_q <= '0;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (xfer && in_last) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        flush_cnt_q <= '0;
                    end else if (pipe_ena) begin
                        if (flush_cnt_q == LW'(LATENCY - 1)) begin
                            state_q      <= ST_IDLE;
                            flush_cnt_q  <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + LW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Enabled-cycle count since frame start, saturating once the pipeline latency is covered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_cnt_q <= '0;
        end else if (clr) begin
            en_cnt_q <= '0;
        end else if (pipe_ena && !lat_reached) begin
            en_cnt_q <= en_cnt_q + LW'(1);
        end
    end

    // Descriptor hold register; a fresh capture wins over a same-cycle downstream acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_desc_q  <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            out_desc_q  <= pipe_desc;
            out_col_q   <= oc_col;
            out_row_q   <= oc_row;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky flag for descriptors that arrived while the hold register could not take them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (go) begin
            overflow_q <= 1'b0;
        end else if (pipe_valid && stall) begin
            overflow_q <= 1'b1;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_desc   = out_desc_q;
    assign out_col    = out_col_q;
    assign out_row    = out_row_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_orb_frame_controller.sv
// tb/tb_orb_frame_controller.sv - randomized self-checking bench for orb_frame_controller
module tb_orb_frame_controller;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int L    = 10;
    localparam int NPIX = W * H;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_pixel = '0;
    logic         in_corner = 1'b0;
    logic         in_ready;
    logic         pipe_ena;
    logic [7:0]   pipe_pixel;
    logic         pipe_corner;
    logic [255:0] pipe_desc = '0;
    logic         pipe_valid = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] out_desc;
    logic [2:0]   out_col;
    logic [1:0]   out_row;
    logic         busy;
    logic         frame_done;
    logic         overflow;

    always #5 clk = ~clk;

    orb_frame_controller #(
        .IMG_W             (W),
        .IMG_H             (H),
        .LATENCY           (L),
        .WIDTH_PIXEL       (8),
        .WIDTH_DESCRIPTORS (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_pixel    (in_pixel),
        .in_corner   (in_corner),
        .in_ready    (in_ready),
        .pipe_ena    (pipe_ena),
        .pipe_pixel  (pipe_pixel),
        .pipe_corner (pipe_corner),
        .pipe_desc   (pipe_desc),
        .pipe_valid  (pipe_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_desc    (out_desc),
        .out_col     (out_col),
        .out_row     (out_row),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: frame phase (0 idle, 1 stream, 2 flush) plus plain counts of events.
    int           m_phase, m_xf, m_en, m_fl, m_tag;
    bit           m_ov, m_vld, m_done;
    logic [255:0] m_desc;

    logic       seen_done, seen_busy, seen_ena, seen_rdy, seen_ov, seen_vld;
    logic [2:0] seen_col;
    logic [1:0] seen_row;

    task automatic model_reset();
        m_phase = 0; m_xf = 0; m_en = 0; m_fl = 0; m_tag = 0;
        m_ov = 0; m_vld = 0; m_done = 0; m_desc = '0;
    endtask

    // One clock cycle: drive inputs on the falling edge, compare, then advance the model across the rising edge.
    task automatic step(input bit st, input bit ab, input bit iv, input bit pv, input bit ordy);
        bit stall, e_ena;
        @(negedge clk);
        start = st; abort = ab; in_valid = iv; pipe_valid = pv; out_ready = ordy;
        in_pixel = 8'($urandom()); in_corner = 1'($urandom());
        for (int i = 0; i < 8; i++) pipe_desc[i*32 +: 32] = $urandom();
        #1;
        stall = m_vld && !ordy;
        e_ena = (m_phase == 1 && iv && !stall) || (m_phase == 2 && !stall);
        check("in_ready", in_ready, m_phase == 1 && !stall);
        check("pipe_ena", pipe_ena, e_ena);
        check("pipe_pixel", pipe_pixel, (e_ena && m_phase == 1) ? in_pixel : 8'd0);
        check("pipe_corner", pipe_corner, (e_ena && m_phase == 1) ? in_corner : 1'b0);
        check("busy", busy, m_phase != 0);
        check("frame_done", frame_done, m_done);
        check("overflow", overflow, m_ov);
        check("out_valid", out_valid, m_vld);
        if (m_vld) begin
            check("out_desc", out_desc, m_desc);
            check("out_col", out_col, m_tag % W);
            check("out_row", out_row, (m_tag / W) % H);
        end
        seen_done = frame_done; seen_busy = busy; seen_ena = pipe_ena; seen_rdy = in_ready;
        seen_ov = overflow; seen_vld = out_valid; seen_col = out_col; seen_row = out_row;

        if (e_ena && pv) begin
            m_vld  = 1;
            m_desc = pipe_desc;
            m_tag  = (m_en >= L) ? (m_en - L) % NPIX : 0;
        end else if (m_vld && ordy) begin
            m_vld = 0;
        end
        if (pv && stall) m_ov = 1;
        m_done = 0;
        if (m_phase == 0) begin
            if (st && !ab) begin
                m_phase = 1; m_xf = 0; m_en = 0; m_fl = 0; m_ov = 0;
            end
        end else if (ab) begin
            m_phase = 0; m_xf = 0; m_en = 0; m_fl = 0;
        end else if (e_ena) begin
            m_en++;
            if (m_phase == 1) begin
                m_xf++;
                if (m_xf == NPIX) m_phase = 2;
            end else begin
                m_fl++;
                if (m_fl == L) begin
                    m_phase = 0;
                    m_done  = 1;
                end
            end
        end
        @(posedge clk);
    endtask

    initial begin
        int n;
        model_reset();

        // Reset state while rst is held low.
        in_valid = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_pipe_ena", pipe_ena, 0);
        check("rst_pipe_pixel", pipe_pixel, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_desc", out_desc, 0);
        check("rst_out_col", out_col, 0);
        check("rst_out_row", out_row, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        step(0, 0, 0, 0, 1);

        // Full frame at full rate: frame_done 42 edges after the start edge.
        step(1, 0, 1, 0, 1);
        n = 0;
        while (n < 100) begin
            step(0, 0, 1, 0, 1);
            if (seen_done) break;
            n++;
        end
        check("req032_done_cycle", n, 42);
        check("req032_busy_fall", seen_busy, 0);

        // Descriptor on enabled cycle 13 is tagged col 3, row 0.
        step(1, 0, 1, 0, 1);
        n = 0;
        while (m_en < 13 && n < 50) begin step(0, 0, 1, 0, 1); n++; end
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 0, 1);
        check("req033_valid", seen_vld, 1);
        check("req033_col", seen_col, 3);
        check("req033_row", seen_row, 0);
        n = 0;
        while (m_phase != 0 && n < 100) begin step(0, 0, 1, 0, 1); n++; end
        if (n >= 100) check("req033_timeout", 0, 1);

        // Backpressure stalls the pipeline; a descriptor arriving during the stall sets overflow.
        step(1, 0, 1, 0, 1);
        step(0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        check("req034_ena", seen_ena, 0);
        check("req034_rdy", seen_rdy, 0);
        check("req034_ov", seen_ov, 0);
        check("req034_held", seen_vld, 1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        check("req035_ov_set", seen_ov, 1);
        n = 0;
        while (m_phase != 0 && n < 200) begin step(0, 0, 1, 0, 1); n++; end
        if (n >= 200) check("req035_timeout", 0, 1);
        step(0, 0, 0, 0, 1);
        check("req035_ov_sticky", seen_ov, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("req035_ov_clear", seen_ov, 0);

        // Abort after 20 transfers, then a restarted frame runs its full length from the origin.
        n = 0;
        while (m_xf < 20 && n < 100) begin step(0, 0, 1, 0, 1); n++; end
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("req036_idle", seen_busy, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
        step(1, 0, 1, 0, 1);
        n = 0;
        while (n < 100) begin
            step(0, 0, 1, 0, 1);
            if (seen_done) break;
            n++;
        end
        check("req036_restart_cycle", n, 42);

        // Randomized frames with backpressure, stray starts, spurious descriptors and rare aborts.
        for (int f = 0; f < 8; f++) begin
            step(1, 0, 0, 0, 1);
            n = 0;
            while (m_phase != 0 && n < 600) begin
                step($urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) < 7);
                n++;
            end
            if (n >= 600) check("rand_timeout", 0, 1);
            for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        end

        // Asynchronous reset in the middle of FLUSH with a descriptor held.
        step(1, 0, 1, 0, 1);
        n = 0;
        while (m_phase != 2 && n < 100) begin step(0, 0, 1, 0, 1); n++; end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", out_valid, 1);
        pipe_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("req037_busy", busy, 0);
        check("req037_out_valid", out_valid, 0);
        check("req037_out_desc", out_desc, 0);
        check("req037_out_col", out_col, 0);
        check("req037_out_row", out_row, 0);
        check("req037_pipe_ena", pipe_ena, 0);
        check("req037_pipe_pixel", pipe_pixel, 0);
        check("req037_in_ready", in_ready, 0);
        check("req037_frame_done", frame_done, 0);
        check("req037_overflow", overflow, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/orb_frame_controller.md
ORB_FRAME_CONTROLLER -- requirements
Module: orb_frame_controller

Interface
REQ-001 SHALL have parameter IMG_W, default 512, pixels per row.
REQ-002 SHALL have parameter IMG_H, default 480, rows per frame.
REQ-003 SHALL have parameter LATENCY, default 11504, enabled cycles from pixel entry to its descriptor at pipeline output.
REQ-004 SHALL have parameter WIDTH_PIXEL, default 8; WIDTH_DESCRIPTORS, default 256.
REQ-005 Ports: clk input 1, sole clock; rst input 1, asynchronous active-low reset.
REQ-006 Ports: start input 1, frame start pulse; abort input 1, cancel the current frame.
REQ-007 Ports: in_valid input 1, in_pixel input WIDTH_PIXEL, in_corner input 1, in_ready output 1; pixel/corner upstream handshake.
REQ-008 Ports: pipe_ena output 1, pipe_pixel output WIDTH_PIXEL, pipe_corner output 1; drive the ORB pipeline ena/pixel/isCorner.
REQ-009 Ports: pipe_desc input WIDTH_DESCRIPTORS, pipe_valid input 1; pipeline descriptor output.
REQ-010 Ports: out_valid output 1, out_ready input 1, out_desc output WIDTH_DESCRIPTORS, out_col output clog2(IMG_W), out_row output clog2(IMG_H); tagged-descriptor downstream handshake.
REQ-011 Ports: busy output 1, frame_done output 1 (one-cycle pulse), overflow output 1 (sticky).

Function
REQ-012 SHALL implement states IDLE, STREAM, FLUSH.
REQ-013 IDLE->STREAM on start; start ignored outside IDLE.
REQ-014 STREAM: in_ready = !stall; pipe_ena = in_valid & !stall; pipe_pixel/pipe_corner = in_pixel/in_corner; transfer when in_valid & in_ready.
REQ-015 STREAM->FLUSH on the transfer of pixel IMG_W*IMG_H-1.
REQ-016 FLUSH: in_ready=0; pipe_ena = !stall; pipe_pixel=0, pipe_corner=0; after exactly LATENCY enabled cycles -> IDLE, frame_done pulsed in that transition cycle.
REQ-017 stall = out_valid & !out_ready.
REQ-018 IDLE: in_ready=0, pipe_ena=0, busy=0; busy=1 in STREAM and FLUSH.
REQ-019 Input counter (col, row) SHALL advance on each STREAM transfer; col wraps IMG_W-1->0 incrementing row.
REQ-020 Output counter (col, row) SHALL advance on every enabled cycle once total enabled cycles in the frame >= LATENCY; it lags the input counter by LATENCY enabled cycles.
REQ-021 Capture: when pipe_ena & pipe_valid, load pipe_desc and output counter value into the hold register and set out_valid next cycle.
REQ-022 out_valid SHALL clear on out_valid & out_ready unless a capture occurs in the same cycle, which reloads (capture wins).
REQ-023 pipe_valid while stall (not capturable) SHALL set overflow; descriptor dropped; overflow cleared only by reset or start.
REQ-024 pipe_valid with pipe_ena=0 SHALL be ignored.
REQ-025 abort in STREAM or FLUSH: -> IDLE next cycle, counters cleared, no frame_done; hold register keeps its contents until drained.
REQ-026 start and abort together in IDLE: abort wins, stay IDLE.
REQ-027 Counters and enabled-cycle count SHALL clear on start.

Reset
REQ-028 On rst low: state IDLE, all counters 0, out_valid=0, out_desc=0, out_col=0, out_row=0, busy=0, frame_done=0, overflow=0, in_ready=0, pipe_ena=0.
REQ-029 pipe_pixel, pipe_corner SHALL be 0 whenever pipe_ena=0.

Structure
REQ-030 Shared package orb_ctrl_pkg SHALL hold the state enumeration and default IMG_W/IMG_H/LATENCY constants.
REQ-031 One sub-module orb_coord_counter (col/row with wrap, enable, clear) SHALL be instantiated twice (input, output).

Verification (IMG_W=8, IMG_H=4, LATENCY=10)
REQ-032 start, in_valid held 1, out_ready=1 -> 32 transfers, 10 FLUSH cycles, frame_done at cycle 42 after start, busy falls with it.
REQ-033 pipe_valid on enabled cycle 13 -> out_valid with out_col=3, out_row=0.
REQ-034 out_ready=0 with out_valid=1 -> pipe_ena and in_ready 0 until out_ready=1; no data lost, overflow=0.
REQ-035 pipe_valid forced during stall -> overflow=1, persists until next start.
REQ-036 abort at transfer 20 -> IDLE next cycle, no frame_done; subsequent start restarts at col=0,row=0.
REQ-037 rst asserted mid-FLUSH -> all outputs at REQ-028 values immediately, asynchronously.
